// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - UART byte input and instruction-memory write bundle for inst_mem_loader
interface inst_mem_loader_if #(
    parameter int len_data = 32
);
    logic                in_load_start;
    logic [7:0]          in_rx_data;
    logic                in_rx_done;
    logic [len_data-1:0] out_ins_to_mem;
    logic [len_data-1:0] out_addr_debug;
    logic                out_wea_ram_inst;
    logic                out_debug_flag;
    logic                out_load_done;
    logic                out_overflow;

    modport master (
        output in_load_start, in_rx_data, in_rx_done,
        input  out_ins_to_mem, out_addr_debug, out_wea_ram_inst,
               out_debug_flag, out_load_done, out_overflow
    );

    modport slave (
        input  in_load_start, in_rx_data, in_rx_done,
        output out_ins_to_mem, out_addr_debug, out_wea_ram_inst,
               out_debug_flag, out_load_done, out_overflow
    );
endinterface

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - assembles big-endian UART bytes into words and writes them to instruction memory
module inst_mem_loader #(
    parameter int                  len_data  = 32,
    parameter int                  ram_depth = 2048,
    parameter logic [len_data-1:0] halt_word = {len_data{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    inst_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ASSEMBLE, ST_WRITE, ST_DONE} state_t;

    localparam logic [len_data-1:0] LAST_ADDR = len_data'(ram_depth - 1);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [len_data-1:0] shift_q, shift_d;
    logic [len_data-1:0] word_q, word_d;
    logic [len_data-1:0] addr_q, addr_d;
    logic                ovf_q, ovf_d;
    logic [len_data-1:0] shifted;

    assign shifted = {shift_q[len_data-9:0], bus.in_rx_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            shift_q <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.in_load_start) begin
                    state_d = ST_ASSEMBLE;
                    cnt_d   = 2'd0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ASSEMBLE: begin
                if (bus.in_rx_done) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        word_d  = shifted;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (word_q == halt_word) begin
                    state_d = ST_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = ST_ASSEMBLE;
                    addr_d  = addr_q + 1'b1;
                    // A byte landing during the write pulse starts the next word.
                    if (bus.in_rx_done) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign bus.out_wea_ram_inst = (state_q == ST_WRITE);
    assign bus.out_debug_flag   = (state_q == ST_ASSEMBLE) || (state_q == ST_WRITE);
    assign bus.out_load_done    = (state_q == ST_DONE);
    assign bus.out_overflow     = ovf_q;
    assign bus.out_ins_to_mem   = word_q;
    assign bus.out_addr_debug   = addr_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for inst_mem_loader with a 4-word memory
module tb_inst_mem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    inst_mem_loader_if #(.len_data(32)) bus ();

    inst_mem_loader #(.len_data(32), .ram_depth(4), .halt_word(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected (addr, data) pair.
    always @(negedge clk) begin
        if (bus.out_wea_ram_inst === 1'b1) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_addr=%h actual_data=%h", bus.out_addr_debug, bus.out_ins_to_mem);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", bus.out_addr_debug, e[63:32]);
                chk("write_data", bus.out_ins_to_mem, e[31:0]);
                chk("write_debug_flag", {31'd0, bus.out_debug_flag}, 32'd1);
            end
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic start_load(input logic with_byte);
        @(posedge clk); #2;
        bus.in_load_start = 1'b1;
        bus.in_rx_done    = with_byte;
        bus.in_rx_data    = 8'hEE;
        @(posedge clk); #2;
        bus.in_load_start = 1'b0;
        bus.in_rx_done    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        bus.in_rx_done = 1'b1;
        bus.in_rx_data = b;
        @(posedge clk); #2;
        bus.in_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic check_latency);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
        end
        if (check_latency) begin
            @(negedge clk);
            chk("write_latency", {31'd0, bus.out_wea_ram_inst}, 32'd1);
        end
    endtask

    task automatic send_stream(input logic [63:0] bytes8);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #2;
            bus.in_rx_done = 1'b1;
            bus.in_rx_data = bytes8[i*8 +: 8];
        end
        @(posedge clk); #2;
        bus.in_rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_status(input string tag, input logic dbg, input logic done, input logic ovf);
        chk({tag, "_debug_flag"}, {31'd0, bus.out_debug_flag}, {31'd0, dbg});
        chk({tag, "_load_done"},  {31'd0, bus.out_load_done},  {31'd0, done});
        chk({tag, "_overflow"},   {31'd0, bus.out_overflow},   {31'd0, ovf});
    endtask

    task automatic chk_all_zero(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b0);
        chk({tag, "_wea"},  {31'd0, bus.out_wea_ram_inst}, 32'd0);
        chk({tag, "_addr"}, bus.out_addr_debug, 32'd0);
        chk({tag, "_data"}, bus.out_ins_to_mem, 32'd0);
    endtask

    initial begin
        bus.in_load_start = 1'b0;
        bus.in_rx_done    = 1'b0;
        bus.in_rx_data    = 8'h00;
        #12;
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);
        chk_all_zero("idle");

        // First word, three-word program ending in HALT at the last address.
        start_load(1'b0);
        chk_status("started", 1'b1, 1'b0, 1'b0);
        expect_write(32'd0, 32'h2001_0005);
        expect_write(32'd1, 32'h0A0B_0C0D);
        expect_write(32'd2, 32'h1234_5678);
        expect_write(32'd3, 32'hFFFF_FFFF);
        send_byte(8'h20);
        chk_status("partial", 1'b1, 1'b0, 1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        @(negedge clk);
        chk("first_write_latency", {31'd0, bus.out_wea_ram_inst}, 32'd1);
        send_word(32'h0A0B_0C0D, 1'b1);
        send_word(32'h1234_5678, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        idle(1);
        chk_status("halt_done", 1'b0, 1'b1, 1'b0);
        send_byte(8'h77);
        idle(1);
        chk_status("done_byte_ignored", 1'b0, 1'b1, 1'b0);

        // Fill all four words without HALT; the fifth word must never be written.
        start_load(1'b0);
        chk_status("restart", 1'b1, 1'b0, 1'b0);
        expect_write(32'd0, 32'h0102_0304);
        expect_write(32'd1, 32'h0506_0708);
        expect_write(32'd2, 32'h090A_0B0C);
        expect_write(32'd3, 32'h0D0E_0F10);
        send_word(32'h0102_0304, 1'b1);
        send_word(32'h0506_0708, 1'b1);
        send_word(32'h090A_0B0C, 1'b1);
        send_word(32'h0D0E_0F10, 1'b1);
        idle(1);
        chk_status("overflow_done", 1'b0, 1'b1, 1'b1);
        send_word(32'h1112_1314, 1'b0);
        idle(2);
        chk_status("overflow_hold", 1'b0, 1'b1, 1'b1);

        // Restart clears overflow; back-to-back bytes including one in each write cycle.
        start_load(1'b0);
        chk_status("ovf_cleared", 1'b1, 1'b0, 1'b0);
        expect_write(32'd0, 32'h0011_2233);
        expect_write(32'd1, 32'h4455_6677);
        send_stream(64'h0011_2233_4455_6677);
        idle(2);
        expect_write(32'd2, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1'b1);
        idle(1);
        chk_status("b2b_done", 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a word.
        start_load(1'b0);
        send_byte(8'h5A);
        send_byte(8'hA5);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        idle(1);
        reset = 1'b0;
        start_load(1'b0);
        expect_write(32'd0, 32'hAABB_CCDD);
        send_word(32'hAABB_CCDD, 1'b1);
        expect_write(32'd1, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1'b1);
        idle(1);
        chk_status("after_reset_done", 1'b0, 1'b1, 1'b0);

        // Bytes in IDLE, a byte coincident with start, and a start pulse mid-word are ignored.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send_byte(8'h99);
        send_byte(8'h88);
        chk_status("idle_bytes", 1'b0, 1'b0, 1'b0);
        start_load(1'b1);
        expect_write(32'd0, 32'h1122_3344);
        send_word(32'h1122_3344, 1'b1);
        expect_write(32'd1, 32'h5566_7788);
        send_byte(8'h55);
        start_load(1'b0);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        @(negedge clk);
        chk("midword_start_write", {31'd0, bus.out_wea_ram_inst}, 32'd1);
        expect_write(32'd2, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1'b1);
        idle(3);
        chk_status("final_done", 1'b0, 1'b1, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Debug-side writer for the fetch stage's instruction memory: takes a byte stream from the debug UART receiver, assembles 32-bit words, and writes them sequentially from address 0.
- Drives the instruction-memory write-enable, address and data inputs of the IF_ID stage.
- Holds debug mode asserted while loading, so the pipeline stays stalled.
- Stops on the HALT word or when memory is full, then reports completion.

Parameters:
- len_data, 32, width of the instruction word and of the address bus.
- ram_depth, 2048, number of instruction-memory words; the last writable address is ram_depth-1.
- halt_word, 32'hFFFFFFFF, end-of-program marker; it is written to memory, then loading stops.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_load_start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_rx_data  in  8  received byte from the UART receiver.
- in_rx_done  in  1  one-cycle strobe; in_rx_data is valid this cycle.
- out_ins_to_mem  out  len_data  assembled word presented to instruction memory.
- out_addr_debug  out  len_data  word address for the write.
- out_wea_ram_inst  out  1  instruction-memory write enable; one-cycle pulse per word.
- out_debug_flag  out  1  high from load start until DONE; holds the pipeline in debug mode.
- out_load_done  out  1  high while in DONE.
- out_overflow  out  1  sticky; memory filled without a HALT word.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte count 0; shift register 0; address 0.
- States:
  - IDLE: all outputs low; in_load_start -> ASSEMBLE with address 0, byte count 0, out_overflow cleared.
  - ASSEMBLE: on each in_rx_done, shift = {shift[23:0], in_rx_data} (first byte received = MSB, big-endian) and count++. When the 4th byte is captured (count 3->0), latch the word into out_ins_to_mem -> WRITE.
  - WRITE: exactly one cycle; out_wea_ram_inst=1 with out_addr_debug and out_ins_to_mem stable. Next state:
    - if word == halt_word -> DONE, out_overflow stays 0;
    - else if address == ram_depth-1 -> DONE and set out_overflow;
    - else address+1 -> ASSEMBLE.
  - DONE: out_load_done=1, out_debug_flag=0, address held; in_load_start -> ASSEMBLE with address 0, count 0, out_load_done and out_overflow cleared.
- Latency: write pulse occurs the cycle after the clock edge that captures the 4th byte.
- Address increments by 1 per word: word addressing, matching the PC step of 1.
- An in_rx_done arriving in the WRITE cycle is captured as byte 0 of the next word (count=1); no byte is lost. An in_rx_done in the same cycle as in_load_start from IDLE/DONE is ignored.
- in_load_start during ASSEMBLE or WRITE is ignored (no restart mid-load).
- in_rx_done in IDLE or DONE is ignored; count and shift register are unchanged.
- A partial word (1-3 bytes) never causes a write; it persists until more bytes arrive or reset.
- out_debug_flag = 1 in ASSEMBLE and WRITE, 0 otherwise.
- out_ins_to_mem and out_addr_debug may hold stale values while out_wea_ram_inst=0; memory must only sample them with write enable high.
- Reset asserted mid-load returns to IDLE immediately (asynchronous), drops out_wea_ram_inst in the same cycle, and discards any partial word.

Test Plan:
- Reset then in_load_start, bytes 20,01,00,05 -> one pulse of out_wea_ram_inst at addr 0 with data 32'h20010005, the cycle after byte 4; out_debug_flag=1 throughout.
- Three words then halt bytes FF,FF,FF,FF -> writes at addr 0,1,2,3 (addr 3 = FFFFFFFF); out_load_done=1, out_overflow=0, out_debug_flag=0.
- ram_depth=4, five non-halt words -> writes at addr 0-3 only; DONE with out_overflow=1; the 5th word is never written; a new in_load_start clears out_overflow and restarts at addr 0.
- in_rx_done asserted in the WRITE cycle (back-to-back bytes, 1 per clock) -> no byte dropped; words 0x00112233, 0x44556677 written at addr 0 and 1.
- Reset asserted after 2 bytes of word 1 -> all outputs 0 immediately; after a new start, 4 bytes AA,BB,CC,DD -> write of 0xAABBCCDD at addr 0.
- Bytes while IDLE, then start, then 11,22,33,44 -> single write of 0x11223344 at addr 0 (IDLE bytes ignored); in_load_start pulsed mid-word -> ignored, address sequence unchanged.
